// File: rtl/swara_tone_pkg.sv
// rtl/swara_tone_pkg.sv - shared types, constants and elaboration-time table builders for the swara tone stage
package swara_tone_pkg;

   typedef enum logic [1:0] {
      WIN_NONE = 2'd0,
      WIN_ASC  = 2'd1,
      WIN_FALL = 2'd2,
      WIN_BOTH = 2'd3
   } win_e;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_PLAY = 1'b1
   } state_e;

   localparam int FS         = 44100;
   localparam int NUM_SWARAS = 21;
   localparam int ENV_MAX    = 32767;

   // Phase step for swara idx: round(320 * 1.104089514**idx * 2**pw / FS).
   // Only evaluated at elaboration to build constant tables.
   function automatic longint phase_inc(input int idx, input int pw);
      real f;
      real scale;
      f     = 320.0;
      scale = 1.0;
      for (int k = 0; k < idx; k++) f = f * 1.104089514;
      for (int k = 0; k < pw; k++) scale = scale * 2.0;
      f = f * scale / real'(FS);
      return longint'($rtoi(f + 0.5));
   endfunction

   // Quarter-wave ROM entry k: round(32767 * sin(pi/2 * k / 2**aw)), via Taylor series
   // so the table is built from plain real arithmetic at elaboration.
   function automatic int sin_q15(input int k, input int aw);
      real x;
      real term;
      real sum;
      x    = 3.141592653589793 / 2.0 * real'(k) / real'(1 << aw);
      term = x;
      sum  = x;
      for (int n = 1; n < 14; n++) begin
         term = -term * x * x / real'((2 * n) * (2 * n + 1));
         sum  = sum + term;
      end
      return $rtoi(32767.0 * sum + 0.5);
   endfunction

   localparam logic [23:0] PHASE_INC [NUM_SWARAS] = '{
      24'(phase_inc(0, 24)),  24'(phase_inc(1, 24)),  24'(phase_inc(2, 24)),
      24'(phase_inc(3, 24)),  24'(phase_inc(4, 24)),  24'(phase_inc(5, 24)),
      24'(phase_inc(6, 24)),  24'(phase_inc(7, 24)),  24'(phase_inc(8, 24)),
      24'(phase_inc(9, 24)),  24'(phase_inc(10, 24)), 24'(phase_inc(11, 24)),
      24'(phase_inc(12, 24)), 24'(phase_inc(13, 24)), 24'(phase_inc(14, 24)),
      24'(phase_inc(15, 24)), 24'(phase_inc(16, 24)), 24'(phase_inc(17, 24)),
      24'(phase_inc(18, 24)), 24'(phase_inc(19, 24)), 24'(phase_inc(20, 24))
   };

endpackage

// File: rtl/swara_sine_lut.sv
// rtl/swara_sine_lut.sv - combinational quarter-wave sine ROM with quadrant mirroring and negation
module swara_sine_lut
   import swara_tone_pkg::*;
#(
   parameter int PHASE_W = 24,
   parameter int LUT_AW  = 8
)(
   input  logic [PHASE_W-1:0] phase,
   output logic signed [15:0] s
);

   localparam int DEPTH = (1 << LUT_AW) + 1;
   localparam int AW1   = LUT_AW + 1;

   logic [15:0]       rom [DEPTH];
   logic [1:0]        quad;
   logic [LUT_AW-1:0] fine;
   logic [LUT_AW:0]   addr;
   logic [15:0]       mag;
   logic              unused_phase_lsbs;

   // Entry 2**LUT_AW holds the peak so mirrored quadrants reach full scale.
   for (genvar k = 0; k < DEPTH; k++) begin : g_rom
      localparam logic [15:0] V = 16'(sin_q15(k, LUT_AW));
      assign rom[k] = V;
   end

   assign unused_phase_lsbs = ^phase[PHASE_W-LUT_AW-3:0];

   // Quadrant decode: mirror address in odd quadrants, negate in the lower half-wave.
   always_comb begin
      quad = phase[PHASE_W-1 -: 2];
      fine = phase[PHASE_W-3 -: LUT_AW];
      addr = quad[0] ? (AW1'(1 << LUT_AW) - {1'b0, fine}) : {1'b0, fine};
      mag  = rom[addr];
      s    = quad[1] ? -$signed(mag) : $signed(mag);
   end

endmodule

// File: rtl/swara_tone_gen.sv
// rtl/swara_tone_gen.sv - note-to-PCM tone stage; optional sample counter under TONE_GEN_SAMPLE_COUNT_EN
module swara_tone_gen
   import swara_tone_pkg::*;
#(
   parameter int NOTE_SAMPLES = 13230,
   parameter int WN           = 120,
   parameter int PHASE_W      = 24,
   parameter int LUT_AW       = 8,
   parameter int SCALE_Q15    = 29491
)(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        note_valid,
   output logic        note_ready,
   input  logic [4:0]  note_swara,
   input  logic [1:0]  note_win,
   output logic        smp_valid,
   input  logic        smp_ready,
   output logic [15:0] smp_data,
   output logic        busy,
   output logic        err_swara
`ifdef TONE_GEN_SAMPLE_COUNT_EN
   ,
   output logic [31:0] smp_count,
   input  logic        cnt_clr
`endif
);

   localparam int                IDX_W    = $clog2(NOTE_SAMPLES + 1);
   localparam int                ENV_STEP = (32768 + WN / 2) / WN;
   localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(NOTE_SAMPLES - 1);
   localparam logic signed [16:0] SCALE_S = 17'(SCALE_Q15);

   state_e              state_q;
   logic [PHASE_W-1:0]  phase_q;
   logic [PHASE_W-1:0]  inc_q;
   win_e                win_q;
   logic                zero_q;
   logic [IDX_W-1:0]    idx_q;
   logic                smp_valid_q;
   logic [15:0]         smp_data_q;
   logic                note_ready_q;
   logic                err_q;

   logic [PHASE_W-1:0]  inc_tab [32];
   logic                swara_ok;
   logic                accept;
   logic                hs;
   logic                last_hs;

   logic [PHASE_W-1:0]  ph_sel;
   logic [IDX_W-1:0]    idx_sel;
   win_e                win_sel;
   logic                zero_sel;
   logic [15:0]         asc_env;
   logic [15:0]         fall_env;
   logic [15:0]         env;
   logic signed [15:0]  s_lut;
   logic signed [32:0]  p1;
   logic signed [17:0]  t1;
   logic signed [34:0]  p2;
   logic signed [15:0]  smp_nxt;

   // Out-of-range swara codes map to a zero step so the phase stays put.
   for (genvar g = 0; g < 32; g++) begin : g_inc
      localparam logic [PHASE_W-1:0] INC = (g < NUM_SWARAS) ? PHASE_W'(phase_inc(g, PHASE_W)) : '0;
      assign inc_tab[g] = INC;
   end

   function automatic logic [15:0] env_ramp(input logic [IDX_W-1:0] k);
      logic [31:0] v;
      v = 32'(k) * 32'(ENV_STEP);
      return (v > 32'(ENV_MAX)) ? 16'(ENV_MAX) : v[15:0];
   endfunction

   assign swara_ok = note_swara < 5'(NUM_SWARAS);
   assign accept   = note_valid & note_ready_q & (state_q == ST_IDLE);
   assign hs       = smp_valid_q & smp_ready;
   assign last_hs  = hs & (idx_q == LAST_IDX);

   // Operands for the next sample: the first sample of an incoming note, or the successor of the current one.
   always_comb begin
      ph_sel   = phase_q;
      idx_sel  = '0;
      win_sel  = win_e'(note_win);
      zero_sel = ~swara_ok;
      if (state_q == ST_PLAY) begin
         ph_sel   = phase_q + inc_q;
         idx_sel  = idx_q + IDX_W'(1);
         win_sel  = win_q;
         zero_sel = zero_q;
      end
   end

   swara_sine_lut #(
      .PHASE_W (PHASE_W),
      .LUT_AW  (LUT_AW)
   ) u_lut (
      .phase (ph_sel),
      .s     (s_lut)
   );

   // Envelope select and the two Q15 multiplies with arithmetic shifts.
   always_comb begin
      asc_env  = (idx_sel < IDX_W'(WN)) ? env_ramp(idx_sel) : 16'(ENV_MAX);
      fall_env = (idx_sel >= IDX_W'(NOTE_SAMPLES - WN)) ? env_ramp(LAST_IDX - idx_sel) : 16'(ENV_MAX);
      case (win_sel)
         WIN_ASC:  env = asc_env;
         WIN_FALL: env = fall_env;
         WIN_BOTH: env = (asc_env < fall_env) ? asc_env : fall_env;
         default:  env = 16'(ENV_MAX);
      endcase
      p1      = s_lut * $signed({1'b0, env});
      t1      = 18'(p1 >>> 15);
      p2      = t1 * SCALE_S;
      smp_nxt = zero_sel ? 16'sd0 : 16'(p2 >>> 15);
   end

   // Note FSM: accept in IDLE, stream NOTE_SAMPLES samples in PLAY; phase survives across notes.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= ST_IDLE;
         phase_q      <= '0;
         inc_q        <= '0;
         win_q        <= WIN_NONE;
         zero_q       <= 1'b0;
         idx_q        <= '0;
         smp_valid_q  <= 1'b0;
         smp_data_q   <= '0;
         note_ready_q <= 1'b0;
         err_q        <= 1'b0;
      end else begin
         err_q <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               note_ready_q <= 1'b1;
               if (accept) begin
                  state_q      <= ST_PLAY;
                  note_ready_q <= 1'b0;
                  inc_q        <= swara_ok ? inc_tab[note_swara] : '0;
                  win_q        <= win_e'(note_win);
                  zero_q       <= ~swara_ok;
                  idx_q        <= '0;
                  smp_valid_q  <= 1'b1;
                  smp_data_q   <= smp_nxt;
                  err_q        <= ~swara_ok;
               end
            end
            ST_PLAY: begin
               if (hs) begin
                  phase_q    <= phase_q + inc_q;
                  idx_q      <= idx_q + IDX_W'(1);
                  smp_data_q <= smp_nxt;
                  if (last_hs) begin
                     state_q      <= ST_IDLE;
                     smp_valid_q  <= 1'b0;
                     note_ready_q <= 1'b1;
                  end
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign note_ready = note_ready_q;
   assign smp_valid  = smp_valid_q;
   assign smp_data   = smp_data_q;
   assign busy       = (state_q == ST_PLAY);
   assign err_swara  = err_q;

`ifdef TONE_GEN_SAMPLE_COUNT_EN
   logic [31:0] cnt_q;

   // Saturating count of accepted samples; clear wins over a same-cycle handshake.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else if (cnt_clr) begin
         cnt_q <= '0;
      end else if (hs && (cnt_q != '1)) begin
         cnt_q <= cnt_q + 32'd1;
      end
   end

   assign smp_count = cnt_q;
`endif

endmodule

// File: tb/tb_swara_tone_gen.sv
// tb/tb_swara_tone_gen.sv - scoreboard bench for swara_tone_gen
module tb_swara_tone_gen;

   localparam int NS       = 13230;
   localparam int WN       = 120;
   localparam int ENV_STEP = 273;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        note_valid;
   logic        note_ready;
   logic [4:0]  note_swara;
   logic [1:0]  note_win;
   logic        smp_valid;
   logic        smp_ready;
   logic [15:0] smp_data;
   logic        busy;
   logic        err_swara;
`ifdef TONE_GEN_SAMPLE_COUNT_EN
   logic [31:0] smp_count;
   logic        cnt_clr;
`endif

   int          total = 0;
   int          bad = 0;
   int          exp_q[$];
   int          seen = 0;
   int          peak = 0;
   int          first_smp = 0;
   int          last_smp = 0;
   int          err_cnt = 0;
   bit          held_pending = 0;
   logic [15:0] held_data = '0;
   bit          bp_mode = 0;
   logic [23:0] m_phase = '0;
   int          sintab[257];

   swara_tone_gen dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .note_valid (note_valid),
      .note_ready (note_ready),
      .note_swara (note_swara),
      .note_win   (note_win),
      .smp_valid  (smp_valid),
      .smp_ready  (smp_ready),
      .smp_data   (smp_data),
      .busy       (busy),
      .err_swara  (err_swara)
`ifdef TONE_GEN_SAMPLE_COUNT_EN
      ,
      .smp_count  (smp_count),
      .cnt_clr    (cnt_clr)
`endif
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input longint act, input longint expv);
      total++;
      if (act !== expv) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", name, act, expv);
      end
   endtask

   function automatic int model_inc(input int i);
      real f;
      f = 320.0 * (1.104089514 ** real'(i)) * 16777216.0 / 44100.0;
      return $rtoi(f + 0.5);
   endfunction

   function automatic int imin(input int a, input int b);
      return (a < b) ? a : b;
   endfunction

   function automatic int model_sample(input logic [23:0] ph, input int i, input int win, input bit zero);
      int q, a, m, s, ea, ef, e;
      longint p;
      if (zero) return 0;
      q  = int'(ph[23:22]);
      a  = int'(ph[21:14]);
      m  = (q % 2 == 1) ? sintab[256 - a] : sintab[a];
      s  = (q >= 2) ? -m : m;
      ea = (i < WN) ? imin(i * ENV_STEP, 32767) : 32767;
      ef = (i >= NS - WN) ? imin((NS - 1 - i) * ENV_STEP, 32767) : 32767;
      case (win)
         1:       e = ea;
         2:       e = ef;
         3:       e = imin(ea, ef);
         default: e = 32767;
      endcase
      p = (longint'(s) * longint'(e)) >>> 15;
      p = (p * 29491) >>> 15;
      return int'(p);
   endfunction

   // Ready pattern: always ready, or ~70% ready when backpressure is on.
   initial begin
      smp_ready = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         smp_ready = bp_mode ? ($urandom_range(0, 9) >= 3) : 1'b1;
      end
   end

   // Monitor: pops the scoreboard on every handshake, checks hold under stall.
   always @(negedge clk) begin
      if (!rst_n) begin
         held_pending = 0;
      end else begin
         if (held_pending && smp_valid) begin
            total++;
            if (smp_data !== held_data) begin
               bad++;
               $display("FAIL hold: got %0h expected %0h", smp_data, held_data);
            end
         end
         held_pending = 0;
         if (smp_valid) begin
            total++;
            if (note_ready !== 1'b0) begin
               bad++;
               $display("FAIL ready_in_play: got %0b expected 0", note_ready);
            end
            if (smp_ready) begin
               if (exp_q.size() == 0) begin
                  total++;
                  bad++;
                  $display("FAIL extra_sample: got %0d expected none", $signed(smp_data));
               end else begin
                  int e;
                  int act;
                  e   = exp_q.pop_front();
                  act = int'($signed(smp_data));
                  total++;
                  if (act != e) begin
                     bad++;
                     $display("FAIL sample[%0d]: got %0d expected %0d", seen, act, e);
                  end
                  if (seen == 0) first_smp = act;
                  last_smp = act;
                  if (act > peak) peak = act;
                  if (-act > peak) peak = -act;
                  seen++;
               end
            end else begin
               held_pending = 1;
               held_data    = smp_data;
            end
         end
         if (err_swara) err_cnt++;
      end
   end

   task automatic send_note(input int sw, input int win);
      int  inc;
      bit  zero;
      int  n;
      zero = (sw >= 21);
      inc  = zero ? 0 : model_inc(sw);
      seen = 0;
      peak = 0;
      for (int i = 0; i < NS; i++) begin
         exp_q.push_back(model_sample(m_phase, i, win, zero));
         m_phase = m_phase + 24'(inc);
      end
      n = 0;
      while (note_ready !== 1'b1 && n < 100) begin
         @(negedge clk);
         #1;
         n++;
      end
      if (note_ready !== 1'b1) check("accept_timeout", 0, 1);
      note_swara = 5'(sw);
      note_win   = 2'(win);
      note_valid = 1'b1;
      @(posedge clk);
      #1;
      note_valid = 1'b0;
   endtask

   task automatic wait_done(input string name);
      int n;
      n = 0;
      while (!(note_ready === 1'b1 && busy === 1'b0) && n < 40000) begin
         @(negedge clk);
         #1;
         n++;
      end
      if (n >= 40000) check({name, "_timeout"}, 0, 1);
      check({name, "_count"}, seen, NS);
      check({name, "_queue_left"}, exp_q.size(), 0);
   endtask

   task automatic wait_seen(input int target);
      int n;
      n = 0;
      while (seen < target && n < 20000) begin
         @(negedge clk);
         #1;
         n++;
      end
      if (seen < target) check("wait_seen_timeout", seen, target);
   endtask

   initial begin
      for (int k = 0; k <= 256; k++)
         sintab[k] = $rtoi(32767.0 * $sin(3.141592653589793 / 2.0 * real'(k) / 256.0) + 0.5);
      rst_n      = 1'b0;
      note_valid = 1'b0;
      note_swara = '0;
      note_win   = '0;
`ifdef TONE_GEN_SAMPLE_COUNT_EN
      cnt_clr    = 1'b0;
`endif
      repeat (3) @(negedge clk);
      #1;
      check("rst_smp_valid", smp_valid, 0);
      check("rst_smp_data", smp_data, 0);
      check("rst_busy", busy, 0);
      check("rst_err", err_swara, 0);
      check("rst_note_ready", note_ready, 0);
      rst_n = 1'b1;
      @(negedge clk);
      #1;
      check("ready_after_rst", note_ready, 1);
      check("phase_after_rst", dut.phase_q, 0);

      // swara 7 (640 Hz), no envelope, full throughput
      send_note(7, 0);
      check("inc_swara7", dut.inc_q, 243479);
      check("busy_in_play", busy, 1);
      wait_done("note7");
      check("note7_first", first_smp, 0);
      total++;
      if (peak < 29485 || peak > 29491) begin
         bad++;
         $display("FAIL note7_peak: got %0d expected 29485..29491", peak);
      end

      // swara 8 with BOTH ramps, phase carried from previous note
      send_note(8, 3);
      wait_done("note8_both");
      check("both_first", first_smp, 0);
      check("both_last", last_smp, 0);
`ifdef TONE_GEN_SAMPLE_COUNT_EN
      check("count_two_notes", smp_count, 26460);
`endif

      // ASC ramp under random backpressure
      bp_mode = 1;
      send_note(3, 1);
      wait_done("asc_bp");
      check("asc_first", first_smp, 0);
      bp_mode = 0;
      check("no_err_yet", err_cnt, 0);

      // invalid swara: error pulse, silent note, phase frozen
      send_note(25, 0);
      wait_done("bad_swara");
      check("err_pulse", err_cnt, 1);
      check("bad_swara_peak", peak, 0);
      check("phase_frozen", dut.phase_q, m_phase);

      // reset in the middle of a note
      send_note(10, 0);
      wait_seen(2000);
`ifdef TONE_GEN_SAMPLE_COUNT_EN
      cnt_clr = 1'b1;
      @(negedge clk);
      #1;
      cnt_clr = 1'b0;
      check("count_clear", smp_count, 0);
`endif
      wait_seen(5000);
      rst_n = 1'b0;
      exp_q.delete();
      m_phase = '0;
      #2;
      check("midrst_valid", smp_valid, 0);
      check("midrst_busy", busy, 0);
      check("midrst_phase", dut.phase_q, 0);
      @(negedge clk);
      #1;
      rst_n = 1'b1;
      @(negedge clk);
      #1;
      check("midrst_ready", note_ready, 1);

      // new note starts from phase 0
      send_note(12, 2);
      wait_seen(20);
      check("post_rst_first", first_smp, 0);
      rst_n = 1'b0;
      exp_q.delete();
      @(negedge clk);
      #1;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
